// File: rtl/alu_op_sequencer_pkg.sv
// Shared types and constants for the ALU operation sequencer.
// Holds the sequencer state encoding, the flag width, the settle counter
// width and the opcode values understood by the attached ALU.
package alu_seq_pkg;

    localparam int FLAGS_W = 4;
    localparam int CNT_W   = 4;

    typedef enum logic [2:0] {
        IDLE,
        LD_A,
        LD_B,
        LD_OP,
        UPDATE,
        SETTLE,
        RESP
    } state_t;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_OR  = 2'd2;
    localparam logic [1:0] OP_AND = 2'd3;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Bundle of request handshake, ALU strobe/bus and response handshake signals.
// The slave modport is the sequencer's view; the master modport is the view
// of whatever surrounds it (command source, ALU register block, consumer).
interface alu_op_sequencer_if
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int OP_W  = 2
) ();

    logic               req_valid;
    logic               req_ready;
    logic [WIDTH-1:0]   req_a;
    logic [WIDTH-1:0]   req_b;
    logic [OP_W-1:0]    req_op;

    logic               load_A;
    logic               load_B;
    logic               load_Op;
    logic               updateRes;
    logic [WIDTH-1:0]   data_in;
    logic [WIDTH-1:0]   alu_result;
    logic [FLAGS_W-1:0] alu_flags;

    logic               rsp_valid;
    logic               rsp_ready;
    logic [WIDTH-1:0]   rsp_result;
    logic [FLAGS_W-1:0] rsp_flags;

    logic               busy;

    modport slave (
        input  req_valid, req_a, req_b, req_op, alu_result, alu_flags, rsp_ready,
        output req_ready, load_A, load_B, load_Op, updateRes, data_in,
        output rsp_valid, rsp_result, rsp_flags, busy
    );

    modport master (
        output req_valid, req_a, req_b, req_op, alu_result, alu_flags, rsp_ready,
        input  req_ready, load_A, load_B, load_Op, updateRes, data_in,
        input  rsp_valid, rsp_result, rsp_flags, busy
    );

endinterface

// File: rtl/alu_op_sequencer_settle_cnt.sv
// Loadable down-counter used while waiting for the ALU result to settle.
// Loading N arms the counter; done pulses for one cycle N+1 cycles later,
// i.e. on the last of N+1 counted cycles after the load edge.
module alu_seq_settle_cnt #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] count_reg;
    logic             active_reg;

    // Count down after a load; disarm once the terminal count is reached.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_reg  <= '0;
            active_reg <= 1'b0;
        end else if (load) begin
            count_reg  <= load_val;
            active_reg <= 1'b1;
        end else if (active_reg) begin
            if (count_reg == '0) begin
                active_reg <= 1'b0;
            end else begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end

    assign done = active_reg && (count_reg == '0);

endmodule

// File: rtl/alu_op_sequencer.sv
// Sequences one ALU transaction: load A, load B, load opcode, update result,
// wait SETTLE_CYCLES, then return result and flags over a response handshake.
// All outputs are registered. Optional macro ALU_SEQ_OPCACHE_EN skips the
// opcode load when the opcode matches the one most recently loaded.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH         = 16,
    parameter int OP_W          = 2,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    alu_op_sequencer_if.slave bus
);

    // Counter is armed with one less than the settle length: it is loaded on
    // the edge leaving UPDATE and reports done on the last SETTLE cycle.
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    state_t             state_reg;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [OP_W-1:0]    op_reg;
    logic               load_a_reg;
    logic               load_b_reg;
    logic               load_op_reg;
    logic               update_res_reg;
    logic [WIDTH-1:0]   data_in_reg;
    logic               rsp_valid_reg;
    logic [WIDTH-1:0]   rsp_result_reg;
    logic [FLAGS_W-1:0] rsp_flags_reg;
    logic               req_ready_reg;
    logic               busy_reg;
    logic               settle_done;
    logic               op_hit;

`ifdef ALU_SEQ_OPCACHE_EN
    logic [OP_W-1:0]    last_op_reg;
    logic               last_op_vld_reg;

    // Remember the opcode the ALU register currently holds.
    always_ff @(posedge clk) begin
        if (!reset) begin
            last_op_reg     <= '0;
            last_op_vld_reg <= 1'b0;
        end else if (state_reg == LD_OP) begin
            last_op_reg     <= op_reg;
            last_op_vld_reg <= 1'b1;
        end
    end

    assign op_hit = last_op_vld_reg && (last_op_reg == op_reg);
`else
    assign op_hit = 1'b0;
`endif

    alu_seq_settle_cnt #(
        .CNT_W    (CNT_W)
    ) u_settle_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (state_reg == UPDATE),
        .load_val (SETTLE_LOAD),
        .done     (settle_done)
    );

    // Transaction FSM; outputs are set alongside the next state so that each
    // strobe is high exactly during the cycle its state is occupied.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg      <= IDLE;
            a_reg          <= '0;
            b_reg          <= '0;
            op_reg         <= '0;
            load_a_reg     <= 1'b0;
            load_b_reg     <= 1'b0;
            load_op_reg    <= 1'b0;
            update_res_reg <= 1'b0;
            data_in_reg    <= '0;
            rsp_valid_reg  <= 1'b0;
            rsp_result_reg <= '0;
            rsp_flags_reg  <= '0;
            req_ready_reg  <= 1'b1;
            busy_reg       <= 1'b0;
        end else begin
            // Strobes and the load bus drop back to zero unless a state sets them.
            load_a_reg     <= 1'b0;
            load_b_reg     <= 1'b0;
            load_op_reg    <= 1'b0;
            update_res_reg <= 1'b0;
            data_in_reg    <= '0;
            case (state_reg)
                IDLE: begin
                    if (bus.req_valid && req_ready_reg) begin
                        a_reg         <= bus.req_a;
                        b_reg         <= bus.req_b;
                        op_reg        <= bus.req_op;
                        load_a_reg    <= 1'b1;
                        data_in_reg   <= bus.req_a;
                        req_ready_reg <= 1'b0;
                        busy_reg      <= 1'b1;
                        state_reg     <= LD_A;
                    end
                end
                LD_A: begin
                    load_b_reg  <= 1'b1;
                    data_in_reg <= b_reg;
                    state_reg   <= LD_B;
                end
                LD_B: begin
                    if (op_hit) begin
                        update_res_reg <= 1'b1;
                        state_reg      <= UPDATE;
                    end else begin
                        load_op_reg <= 1'b1;
                        data_in_reg <= {{(WIDTH-OP_W){1'b0}}, op_reg};
                        state_reg   <= LD_OP;
                    end
                end
                LD_OP: begin
                    update_res_reg <= 1'b1;
                    state_reg      <= UPDATE;
                end
                UPDATE: begin
                    state_reg <= SETTLE;
                end
                SETTLE: begin
                    if (settle_done) begin
                        rsp_result_reg <= bus.alu_result;
                        rsp_flags_reg  <= bus.alu_flags;
                        rsp_valid_reg  <= 1'b1;
                        state_reg      <= RESP;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        req_ready_reg <= 1'b1;
                        busy_reg      <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid_reg <= 1'b0;
                    req_ready_reg <= 1'b1;
                    busy_reg      <= 1'b0;
                    state_reg     <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready  = req_ready_reg;
    assign bus.load_A     = load_a_reg;
    assign bus.load_B     = load_b_reg;
    assign bus.load_Op    = load_op_reg;
    assign bus.updateRes  = update_res_reg;
    assign bus.data_in    = data_in_reg;
    assign bus.rsp_valid  = rsp_valid_reg;
    assign bus.rsp_result = rsp_result_reg;
    assign bus.rsp_flags  = rsp_flags_reg;
    assign bus.busy       = busy_reg;

endmodule
